timer_irq_unit: RTL and testbench

Memory-mapped timer peripheral that produces the `IRQ` request consumed by the instruction control decoder. It sits on the data-memory bus beside data RAM. It counts a reload-style timer and raises a level interrupt on overflow. The interrupt is held until software clears it and is masked while the CPU runs in kernel mode.

---
 rtl/timer_bus_if.sv | 29 ++
 rtl/timer_irq_unit.sv | 138 +++++++++++++
 tb/tb_timer_irq_unit.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/timer_bus_if.sv
// -----------------------------------------------------------------------------
// timer_bus_if
// Data-memory bus slice seen by the timer peripheral.
//   addr   : byte address from the EX/MEM stage
//   mem_rd : read strobe
//   mem_wr : write strobe
//   wdata  : store data
//   rdata  : read data from the peripheral (0 when not selected)
//   hit    : address falls inside the peripheral's 32-byte window
// master = CPU side, slave = peripheral side.
// -----------------------------------------------------------------------------
interface timer_bus_if;
  logic [31:0] addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        hit;

  modport master (
    output addr, mem_rd, mem_wr, wdata,
    input  rdata, hit
  );

  modport slave (
    input  addr, mem_rd, mem_wr, wdata,
    output rdata, hit
  );
endinterface

// File: rtl/timer_irq_unit.sv
// -----------------------------------------------------------------------------
// timer_irq_unit
// Memory-mapped reload timer with a level interrupt, free-running SYSTICK and
// a prescaler. The interrupt is masked while the CPU runs in kernel mode.
//
// Ports:
//   clk    : core clock, all state changes on the rising edge
//   reset  : synchronous, active-low reset
//   kernel : PC[31] of the instruction in flight (1 = kernel mode)
//   irq    : interrupt request, ST & IE & ~kernel
//   bus    : data-memory bus slave (addr, mem_rd, mem_wr, wdata, rdata, hit)
//
// Register map (offset from BASE_ADDR, addr[1:0] ignored):
//   0x00 TH      reload value, R/W
//   0x04 TL      counter, R/W
//   0x08 TCON    [0] EN, [1] IE, [2] ST; upper bits read 0
//   0x0C SYSTICK free-running cycle counter, read-only
//   0x10 PSC     current prescaler count, read-only
//   0x14..0x1C   read 0, writes ignored
// -----------------------------------------------------------------------------
module timer_irq_unit #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        kernel,
  output logic        irq,
  timer_bus_if.slave  bus
);

  typedef enum logic [2:0] {
    REG_TH      = 3'd0,
    REG_TL      = 3'd1,
    REG_TCON    = 3'd2,
    REG_SYSTICK = 3'd3,
    REG_PSC     = 3'd4
  } reg_sel_e;

  localparam logic [15:0] PSC_LAST = 16'(PRESCALE - 1);

  logic [31:0] th;
  logic [31:0] tl;
  logic [31:0] systick;
  logic [15:0] psc;
  logic        en;
  logic        ie;
  logic        st;

  reg_sel_e    sel;
  logic        wr_th;
  logic        wr_tl;
  logic        wr_tcon;
  logic        tick;
  logic        ovf;
  logic        ovf_set;

  // Byte lane bits carry no meaning for a word-only register file.
  logic        unused_ok;
  assign unused_ok = &{1'b0, bus.addr[1:0]};

  assign bus.hit = (bus.addr[31:5] == BASE_ADDR[31:5]);
  assign sel     = reg_sel_e'(bus.addr[4:2]);

  assign wr_th   = bus.mem_wr && bus.hit && (sel == REG_TH);
  assign wr_tl   = bus.mem_wr && bus.hit && (sel == REG_TL);
  assign wr_tcon = bus.mem_wr && bus.hit && (sel == REG_TCON);

  assign tick    = en && (psc == PSC_LAST);
  assign ovf     = tick && (tl == 32'hFFFF_FFFF);
  assign ovf_set = ovf && ie;

  // Combinational from registered ST/IE so kernel entry masks the request
  // in the same cycle.
  assign irq = st && ie && !kernel;

  always_comb begin
    // NOTE: assign a default before the case so no path leaves rdata
    // unassigned; a missing default here would infer a latch.
    bus.rdata = 32'd0;
    if (bus.mem_rd && bus.hit) begin
      case (sel)
        REG_TH:      bus.rdata = th;
        REG_TL:      bus.rdata = tl;
        REG_TCON:    bus.rdata = {29'd0, st, ie, en};
        REG_SYSTICK: bus.rdata = systick;
        REG_PSC:     bus.rdata = {16'd0, psc};
        default:     bus.rdata = 32'd0;
      endcase
    end
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values; reset is sampled only at the clock edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      th      <= 32'd0;
      tl      <= 32'd0;
      systick <= 32'd0;
      psc     <= 16'd0;
      en      <= 1'b0;
      ie      <= 1'b0;
      st      <= 1'b0;
    end else begin
      systick <= systick + 32'd1;

      // A TCON write restarts the prescale period; the tick computed from
      // the current state still takes effect on this edge.
      if (wr_tcon) begin
        psc <= 16'd0;
      end else if (en) begin
        psc <= tick ? 16'd0 : psc + 16'd1;
      end

      if (wr_th) begin
        th <= bus.wdata;
      end

      // A CPU write to TL wins over a coincident tick. On overflow TL loads
      // the pre-edge TH even if TH is being written on the same edge.
      if (wr_tl) begin
        tl <= bus.wdata;
      end else if (tick) begin
        tl <= ovf ? th : tl + 32'd1;
      end

      if (wr_tcon) begin
        en <= bus.wdata[0];
        ie <= bus.wdata[1];
      end

      // Overflow-set dominates a software clear on the same edge so no
      // interrupt is lost.
      st <= (wr_tcon ? bus.wdata[2] : st) | ovf_set;
    end
  end

endmodule

// File: tb/tb_timer_irq_unit.sv
// -----------------------------------------------------------------------------
// tb_timer_irq_unit
// Two instances share clk/reset/kernel: u_dut1 with PRESCALE=1 and u_dut4
// with PRESCALE=4. Inputs are driven 1 time unit after the rising edge, read
// data is sampled on the falling edge. Expected read values are queued when
// the read is issued and compared when the data is sampled.
// -----------------------------------------------------------------------------
module tb_timer_irq_unit;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic clk    = 1'b0;
  logic reset  = 1'b0;
  logic kernel = 1'b0;
  logic irq1;
  logic irq4;

  timer_bus_if if1 ();
  timer_bus_if if4 ();

  timer_irq_unit #(.BASE_ADDR(BASE), .PRESCALE(1)) u_dut1 (
    .clk    (clk),
    .reset  (reset),
    .kernel (kernel),
    .irq    (irq1),
    .bus    (if1.slave)
  );

  timer_irq_unit #(.BASE_ADDR(BASE), .PRESCALE(4)) u_dut4 (
    .clk    (clk),
    .reset  (reset),
    .kernel (kernel),
    .irq    (irq4),
    .bus    (if4.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
    int          dut;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic drive(input int d, input logic rd_en, input logic wr_en,
                       input logic [31:0] a, input logic [31:0] wd);
    if1.addr = 32'd0; if1.mem_rd = 1'b0; if1.mem_wr = 1'b0; if1.wdata = 32'd0;
    if4.addr = 32'd0; if4.mem_rd = 1'b0; if4.mem_wr = 1'b0; if4.wdata = 32'd0;
    if (d == 1) begin
      if1.addr = a; if1.mem_rd = rd_en; if1.mem_wr = wr_en; if1.wdata = wd;
    end else if (d == 4) begin
      if4.addr = a; if4.mem_rd = rd_en; if4.mem_wr = wr_en; if4.wdata = wd;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_raw(input int d, input logic [31:0] a, input logic [31:0] data);
    drive(d, 1'b0, 1'b1, a, data);
    next_cycle();
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic wr(input int d, input logic [4:0] off, input logic [31:0] data);
    wr_raw(d, BASE + 32'(off), data);
  endtask

  task automatic rd(input int d, input logic [4:0] off, input logic [31:0] exp,
                    input string tag);
    exp_t e;
    sb.push_back('{tag: tag, exp: exp, dut: d});
    drive(d, 1'b1, 1'b0, BASE + 32'(off), 32'd0);
    @(negedge clk);
    e = sb.pop_front();
    check(e.tag, (e.dut == 1) ? if1.rdata : if4.rdata, e.exp);
    next_cycle();
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic probe_hit(input int d, input logic [31:0] a, input logic exp,
                           input string tag);
    drive(d, 1'b0, 1'b0, a, 32'd0);
    #1;
    check(tag, {31'd0, (d == 1) ? if1.hit : if4.hit}, {31'd0, exp});
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic check_irq(input string tag, input logic exp);
    check(tag, {31'd0, irq1}, {31'd0, exp});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);

    // Reset held for two edges, then released.
    @(posedge clk); #1;
    check_irq("irq_in_reset", 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;

    rd(1, 5'h00, 32'd0, "th_reset");
    rd(1, 5'h0C, 32'd1, "systick_1");
    rd(1, 5'h0C, 32'd2, "systick_2");
    rd(1, 5'h04, 32'd0, "tl_reset");
    rd(1, 5'h08, 32'd0, "tcon_reset");
    check_irq("irq_after_reset", 1'b0);
    check("irq4_after_reset", {31'd0, irq4}, 32'd0);

    // Reload and interrupt, PRESCALE=1.
    wr(1, 5'h00, 32'hFFFF_FFFC);
    wr(1, 5'h04, 32'hFFFF_FFFE);
    wr(1, 5'h08, 32'd3);
    check_irq("irq_before_ovf", 1'b0);
    rd(1, 5'h04, 32'hFFFF_FFFE, "tl_enable_cycle");
    rd(1, 5'h04, 32'hFFFF_FFFF, "tl_one_after_enable");
    check_irq("irq_after_reload", 1'b1);
    rd(1, 5'h08, 32'd7, "tcon_st_set");
    rd(1, 5'h04, 32'hFFFF_FFFD, "tl_after_reload");
    rd(1, 5'h04, 32'hFFFF_FFFE, "tl_run_fe");
    rd(1, 5'h04, 32'hFFFF_FFFF, "tl_run_ff");
    rd(1, 5'h04, 32'hFFFF_FFFC, "tl_second_reload");

    // Kernel masking and software clear.
    kernel = 1'b1; #1;
    check_irq("irq_kernel_mask", 1'b0);
    wr(1, 5'h08, 32'd3);
    kernel = 1'b0; #1;
    check_irq("irq_after_clear", 1'b0);
    rd(1, 5'h08, 32'd3, "tcon_cleared");

    // Clear on the overflow edge: the overflow-set wins.
    wr(1, 5'h08, 32'd3);
    check_irq("irq_collision", 1'b1);
    rd(1, 5'h08, 32'd7, "tcon_collision");
    wr(1, 5'h08, 32'd0);

    // TL write coinciding with a tick.
    wr(1, 5'h08, 32'd1);
    wr(1, 5'h04, 32'h10);
    rd(1, 5'h04, 32'h10, "tl_write_wins");
    rd(1, 5'h04, 32'h11, "tl_after_write");
    wr(1, 5'h08, 32'd0);
    rd(1, 5'h04, 32'h13, "tl_held_en0");

    // Decode: out-of-window and unmapped offsets.
    probe_hit(1, 32'h4000_0020, 1'b0, "hit_0x20");
    wr_raw(1, 32'h4000_0020, 32'hFFFF_FFFF);
    probe_hit(1, 32'h4000_0014, 1'b1, "hit_0x14");
    wr_raw(1, 32'h4000_0014, 32'hFFFF_FFFF);
    rd(1, 5'h14, 32'd0, "rdata_unmapped");
    rd(1, 5'h00, 32'hFFFF_FFFC, "th_unchanged");
    rd(1, 5'h04, 32'h13, "tl_unchanged");
    rd(1, 5'h08, 32'd0, "tcon_unchanged");

    // Prescaler, PRESCALE=4.
    wr(4, 5'h04, 32'd0);
    wr(4, 5'h08, 32'd1);
    rd(4, 5'h10, 32'd0, "psc_0");
    rd(4, 5'h10, 32'd1, "psc_1");
    rd(4, 5'h10, 32'd2, "psc_2");
    rd(4, 5'h10, 32'd3, "psc_3");
    rd(4, 5'h10, 32'd0, "psc_wrap");
    rd(4, 5'h04, 32'd1, "tl_after_4");
    next_cycle();
    next_cycle();
    rd(4, 5'h04, 32'd2, "tl_after_8");
    rd(4, 5'h10, 32'd1, "psc_before_tcon_wr");
    wr(4, 5'h08, 32'd1);
    rd(4, 5'h10, 32'd0, "psc_tcon_clear");
    rd(4, 5'h10, 32'd1, "psc_restart");
    rd(4, 5'h04, 32'd2, "tl_no_early_tick");

    // Reset with an interrupt pending.
    wr(1, 5'h08, 32'd6);
    check_irq("irq_sw_set", 1'b1);
    reset = 1'b0;
    next_cycle();
    reset = 1'b1;
    check_irq("irq_reset_discard", 1'b0);
    rd(1, 5'h08, 32'd0, "tcon_after_reset");
    rd(1, 5'h00, 32'd0, "th_after_reset");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
